// File: rtl/fifo_write.sv
// FIFO write-side burst generator: waits for an empty FIFO, then streams a
// selectable data pattern until the FIFO reports full or the enable drops.
module fifo_write #(
  parameter logic [7:0] SEED  = 8'h00,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       pattern_sel,
  input  logic             wrempty,
  input  logic             wrfull,
  output logic             wrreq,
  output logic [7:0]       data,
  output logic             burst_done,
  output logic [CNT_W-1:0] fill_count
);

  typedef enum logic [1:0] {IDLE, WAIT_EMPTY, FILL} state_e;

  localparam logic [1:0] PAT_INC  = 2'b00;
  localparam logic [1:0] PAT_DEC  = 2'b01;
  localparam logic [1:0] PAT_LFSR = 2'b10;

  state_e           state_q, state_d;
  logic             wrreq_q, wrreq_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pat_q, pat_d;
  logic             accept;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; all-zero state is forced to 1.
  function automatic logic [7:0] next_word(input logic [1:0] pat, input logic [7:0] d);
    logic [7:0] n;
    case (pat)
      PAT_INC:  n = d + 8'd1;
      PAT_DEC:  n = d - 8'd1;
      PAT_LFSR: n = (d == 8'h00) ? 8'h01 : {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
      default:  n = SEED;
    endcase
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    wrreq_d = wrreq_q;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    accept  = wrreq_q & ~wrfull;

    if (accept) begin
      data_d = next_word(pat_q, data_q);
      if (~&cnt_q) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    case (state_q)
      IDLE: begin
        if (en) state_d = WAIT_EMPTY;
      end
      WAIT_EMPTY: begin
        if (!en) begin
          state_d = IDLE;
        end else if (wrempty) begin
          state_d = FILL;
          wrreq_d = 1'b1;
          cnt_d   = '0;
          pat_d   = pattern_sel;
        end
      end
      FILL: begin
        // full wins over a simultaneous enable drop so the burst still reports done
        if (wrfull) begin
          wrreq_d = 1'b0;
          done_d  = 1'b1;
          state_d = en ? WAIT_EMPTY : IDLE;
        end else if (!en) begin
          wrreq_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        wrreq_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wrreq_q <= 1'b0;
      data_q  <= SEED;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      pat_q   <= PAT_INC;
    end else begin
      state_q <= state_d;
      wrreq_q <= wrreq_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
    end
  end

  assign wrreq      = wrreq_q;
  assign data       = data_q;
  assign burst_done = done_q;
  assign fill_count = cnt_q;

endmodule

// File: tb/tb_fifo_write.sv
// Self-checking bench for fifo_write: a behavioural burst model plus a
// simple FIFO occupancy model drive the flags; outputs are checked every cycle.
module tb_fifo_write;

  localparam logic [7:0] SEED  = 8'h00;
  localparam int         CNT_W = 16;
  localparam int         CMAX  = (1 << CNT_W) - 1;
  localparam int         P_IDLE = 0, P_WAIT = 1, P_FILL = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1, en = 1'b0, wrempty = 1'b0, wrfull = 1'b0;
  logic [1:0]       pattern_sel = 2'b00;
  logic             wrreq, burst_done;
  logic [7:0]       data;
  logic [CNT_W-1:0] fill_count;

  int checks = 0, failures = 0;

  // reference model
  int         m_phase;
  logic       m_wrreq, m_done;
  logic [7:0] m_data;
  int         m_cnt;
  logic [1:0] m_pat;

  // FIFO environment
  int         fifo_cnt = 0, depth = 16;
  logic [7:0] wq[$];

  fifo_write #(.SEED(SEED), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
    .wrempty(wrempty), .wrfull(wrfull), .wrreq(wrreq), .data(data),
    .burst_done(burst_done), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] nxt(input logic [1:0] p, input logic [7:0] d);
    int v, fb;
    v = int'(d);
    case (p)
      2'b00: v = (v + 1) % 256;
      2'b01: v = (v + 255) % 256;
      2'b10: begin
        if (v == 0) v = 1;
        else begin
          fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
          v  = ((v * 2) % 256) + fb;
        end
      end
      default: v = int'(SEED);
    endcase
    return v[7:0];
  endfunction

  function automatic logic [25:0] act();
    return {wrreq, data, burst_done, fill_count};
  endfunction

  function automatic logic [25:0] exp_v();
    return {m_wrreq, m_data, m_done, m_cnt[15:0]};
  endfunction

  // Drive one cycle, advance the model, land 1 time unit after the edge.
  task automatic step(input logic r, input logic e, input logic [1:0] s,
                      input logic we, input logic wf);
    rst = r; en = e; pattern_sel = s; wrempty = we; wrfull = wf;
    if (wrreq && !wf) wq.push_back(data);
    if (r) begin
      m_phase = P_IDLE; m_wrreq = 1'b0; m_data = SEED; m_done = 1'b0;
      m_cnt = 0; m_pat = 2'b00;
    end else begin
      m_done = 1'b0;
      if (m_wrreq && !wf) begin
        m_data = nxt(m_pat, m_data);
        if (m_cnt < CMAX) m_cnt++;
      end
      case (m_phase)
        P_IDLE: if (e) m_phase = P_WAIT;
        P_WAIT: begin
          if (!e) m_phase = P_IDLE;
          else if (we) begin
            m_phase = P_FILL; m_wrreq = 1'b1; m_cnt = 0; m_pat = s;
          end
        end
        default: begin
          if (wf) begin
            m_wrreq = 1'b0; m_done = 1'b1; m_phase = e ? P_WAIT : P_IDLE;
          end else if (!e) begin
            m_wrreq = 1'b0; m_phase = P_IDLE;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fstep(input logic e, input logic [1:0] s);
    logic we, wf, a;
    we = (fifo_cnt == 0);
    wf = (fifo_cnt >= depth);
    a  = wrreq && !wf;
    step(1'b0, e, s, we, wf);
    if (a) fifo_cnt++;
  endtask

  task automatic start_env(input int d);
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    fifo_cnt = 0; depth = d; wq.delete();
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    checks++;
    if (act() !== {1'b0, SEED, 1'b0, 16'd0}) begin
      failures++; $display("FAIL reset_state got=%h want=%h", act(), {1'b0, SEED, 1'b0, 16'd0});
    end
    // enable held but FIFO never empty: no write request may appear
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      checks++;
      if (wrreq !== 1'b0) begin
        failures++; $display("FAIL reset_no_early_wrreq cyc=%0d got=%b want=0", i, wrreq);
      end
    end
  endtask

  task automatic test_increment_fill();
    int ndone = 0;
    logic seen = 1'b0;
    start_env(16);
    for (int i = 0; i < 40 && !seen; i++) begin
      fstep(1'b1, 2'b00);
      checks++;
      if (act() !== exp_v()) begin
        failures++; $display("FAIL inc_cycle cyc=%0d got=%h want=%h", i, act(), exp_v());
      end
      if (burst_done) begin ndone++; seen = 1'b1; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL inc_timeout got=no_done want=done"); end
    checks++;
    if (wq.size() != 16) begin
      failures++; $display("FAIL inc_count got=%0d want=16", wq.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (wq[i] !== 8'(i)) begin
          failures++; $display("FAIL inc_word idx=%0d got=%h want=%h", i, wq[i], 8'(i));
        end
      end
    end
    checks++;
    if (wrreq !== 1'b0 || fill_count !== 16'd16) begin
      failures++; $display("FAIL inc_end got=wrreq%b/cnt%0d want=wrreq0/cnt16", wrreq, fill_count);
    end
    fstep(1'b0, 2'b00);
    if (burst_done) ndone++;
    checks++;
    if (ndone != 1) begin failures++; $display("FAIL inc_done_pulses got=%0d want=1", ndone); end
  endtask

  task automatic test_wrap_continuity();
    logic [7:0] exp_w[8];
    logic seen;
    exp_w = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    start_env(254);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      fstep(1'b1, 2'b00);
      checks++;
      if (act() !== exp_v()) begin
        failures++; $display("FAIL wrap_pre cyc=%0d got=%h want=%h", i, act(), exp_v());
      end
      seen = burst_done;
    end
    checks++;
    if (!seen || data !== 8'hFE) begin
      failures++; $display("FAIL wrap_preload got=%h want=fe", data);
    end
    for (int b = 0; b < 2; b++) begin
      fifo_cnt = 0; depth = 4; wq.delete(); seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        fstep(1'b1, 2'b00);
        seen = burst_done;
      end
      checks++;
      if (!seen || wq.size() != 4) begin
        failures++; $display("FAIL wrap_burst b=%0d got=%0d words want=4", b, wq.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (wq[i] !== exp_w[b*4+i]) begin
            failures++; $display("FAIL wrap_word b=%0d idx=%0d got=%h want=%h", b, i, wq[i], exp_w[b*4+i]);
          end
        end
      end
    end
  endtask

  task automatic test_lfsr();
    logic [7:0] first[5];
    int zeros = 0;
    logic seen = 1'b0;
    first = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    start_env(256);
    for (int i = 0; i < 300 && !seen; i++) begin
      fstep(1'b1, 2'b10);
      checks++;
      if (act() !== exp_v()) begin
        failures++; $display("FAIL lfsr_cycle cyc=%0d got=%h want=%h", i, act(), exp_v());
      end
      seen = burst_done;
    end
    checks++;
    if (wq.size() != 256) begin
      failures++; $display("FAIL lfsr_count got=%0d want=256", wq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wq[i+1] !== first[i]) begin
          failures++; $display("FAIL lfsr_first idx=%0d got=%h want=%h", i, wq[i+1], first[i]);
        end
      end
      for (int i = 1; i < 256; i++) if (wq[i] == 8'h00) zeros++;
      checks++;
      if (zeros != 0) begin failures++; $display("FAIL lfsr_zero got=%0d want=0", zeros); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] held;
    start_env(16);
    for (int i = 0; i < 20 && !(wrreq && fill_count == 16'd2); i++) fstep(1'b1, 2'b00);
    fstep(1'b0, 2'b00);
    checks++;
    if ({wrreq, burst_done, fill_count, data} !== {1'b0, 1'b0, 16'd3, 8'h03}) begin
      failures++; $display("FAIL abort_end got=%b/%b/%0d/%h want=0/0/3/03", wrreq, burst_done, fill_count, data);
    end
    held = data;
    for (int i = 0; i < 3; i++) begin
      fstep(1'b0, 2'b00);
      checks++;
      if (data !== held || wrreq !== 1'b0 || burst_done !== 1'b0) begin
        failures++; $display("FAIL abort_hold got=%h/%b/%b want=%h/0/0", data, wrreq, burst_done, held);
      end
    end
    fifo_cnt = 0;
    fstep(1'b1, 2'b00);
    checks++;
    if (wrreq !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b want=0", wrreq); end
    fstep(1'b1, 2'b00);
    checks++;
    if (wrreq !== 1'b1) begin failures++; $display("FAIL abort_restart got=%b want=1", wrreq); end
  endtask

  task automatic test_simultaneous();
    start_env(16);
    for (int i = 0; i < 20 && !(wrreq && fill_count == 16'd5); i++) fstep(1'b1, 2'b00);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checks++;
    if ({burst_done, wrreq, fill_count} !== {1'b1, 1'b0, 16'd5}) begin
      failures++; $display("FAIL simul_end got=%b/%b/%0d want=1/0/5", burst_done, wrreq, fill_count);
    end
    step(1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    checks++;
    if (wrreq !== 1'b0 || burst_done !== 1'b0) begin
      failures++; $display("FAIL simul_idle got=%b/%b want=0/0", wrreq, burst_done);
    end
    step(1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    checks++;
    if (wrreq !== 1'b1) begin failures++; $display("FAIL simul_restart got=%b want=1", wrreq); end
  endtask

  task automatic test_reset_mid_fill();
    start_env(16);
    for (int i = 0; i < 20 && !(wrreq && fill_count == 16'd4); i++) fstep(1'b1, 2'b00);
    step(1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    checks++;
    if (act() !== {1'b0, SEED, 1'b0, 16'd0}) begin
      failures++; $display("FAIL rstfill_state got=%h want=%h", act(), {1'b0, SEED, 1'b0, 16'd0});
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      checks++;
      if (wrreq !== 1'b0) begin failures++; $display("FAIL rstfill_quiet cyc=%0d got=%b want=0", i, wrreq); end
    end
    step(1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    checks++;
    if (wrreq !== 1'b1 || data !== SEED) begin
      failures++; $display("FAIL rstfill_resume got=%b/%h want=1/%h", wrreq, data, SEED);
    end
  endtask

  task automatic test_random();
    logic r, e, we, wf;
    logic [1:0] s;
    start_env(16);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 9) != 0);
      s  = 2'($urandom_range(0, 3));
      we = ($urandom_range(0, 3) == 0);
      wf = ($urandom_range(0, 7) == 0);
      step(r, e, s, we, wf);
      checks++;
      if (act() !== exp_v()) begin
        failures++; $display("FAIL random cyc=%0d got=%h want=%h", i, act(), exp_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_increment_fill();
    test_wrap_continuity();
    test_lfsr();
    test_abort();
    test_simultaneous();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write.md
FIFO_WRITE -- requirements
Module: fifo_write

Interface
REQ-001 The block SHALL have parameter SEED, default 8'h00, giving the first data word after reset.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of fill_count.
REQ-003 Port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1, reset, synchronous and active-high.
REQ-005 Port en, input, 1, level enable; 1 means run write bursts.
REQ-006 Port pattern_sel, input, 2, data pattern: 00 increment, 01 decrement, 10 LFSR, 11 constant SEED.
REQ-007 Port wrempty, input, 1, FIFO write-side empty flag.
REQ-008 Port wrfull, input, 1, FIFO write-side full flag.
REQ-009 Port wrreq, output, 1, registered FIFO write request.
REQ-010 Port data, output, 8, registered FIFO write data.
REQ-011 Port burst_done, output, 1, one-cycle pulse at the normal end of a burst.
REQ-012 Port fill_count, output, CNT_W, words accepted in the current or last burst.

Function
REQ-013 A write SHALL be accepted in a cycle where wrreq=1 and wrfull=0; no other cycle counts as a write.
REQ-014 The FSM SHALL have three states: IDLE, WAIT_EMPTY and FILL.
REQ-015 IDLE: wrreq=0; en=1 -> WAIT_EMPTY on the next edge; en=0 -> stay in IDLE.
REQ-016 WAIT_EMPTY: en=0 -> IDLE; en=1 and wrempty=1 -> FILL, wrreq<=1, fill_count<=0, pattern_sel latched; otherwise stay.
REQ-017 FILL, wrfull=1 sampled: wrreq<=0, burst_done<=1 for one cycle, next state WAIT_EMPTY if en=1, else IDLE.
REQ-018 FILL, wrfull=0 and en=0: wrreq<=0, next state IDLE, no burst_done.
REQ-019 FILL, wrfull=0 and en=1: wrreq stays 1 and the state stays FILL.
REQ-020 wrfull SHALL take priority over en=0 when both occur in the same FILL cycle.
REQ-021 data SHALL advance only on an accepted write; it SHALL hold while wrreq=0 or wrfull=1.
REQ-022 Increment: data<=data+1 mod 256; 8'hFF wraps to 8'h00.
REQ-023 Decrement: data<=data-1 mod 256; 8'h00 wraps to 8'hFF.
REQ-024 LFSR: Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift left, feedback bit = d[7]^d[5]^d[4]^d[3] into bit 0.
REQ-025 LFSR at value 8'h00 SHALL load 8'h01 in place of the shift, so the LFSR never locks up.
REQ-026 Constant: data SHALL hold SEED.
REQ-027 data SHALL continue across bursts and SHALL re-initialise only on reset.
REQ-028 A pattern_sel change during FILL SHALL have no effect until the next WAIT_EMPTY->FILL transition.
REQ-029 fill_count SHALL increment on each accepted write, saturate at all-ones, and hold its value outside FILL.
REQ-030 Latency: wrreq SHALL rise one cycle after wrempty=1 is sampled in WAIT_EMPTY, and fall one cycle after wrfull=1 is sampled in FILL.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, wrreq=0, data=SEED, burst_done=0, fill_count=0, latched pattern=00.
REQ-032 rst SHALL override every other input, including mid-FILL: wrreq drops on the same edge, and no burst_done is produced.
REQ-033 With rst=0 and en=1 held, the first wrreq SHALL NOT rise before wrempty=1 has been sampled in WAIT_EMPTY.

Verification
REQ-034 Increment fill: SEED=0, pattern 00, en=1, wrempty=1, 16-deep FIFO model -> data 0x00..0x0F written, wrfull seen, wrreq low the next cycle, burst_done pulses once, fill_count=16.
REQ-035 Wrap and continuity: SEED=8'hFE, pattern 00, two 4-word bursts -> sequence FE,FF,00,01 then 02,03,04,05.
REQ-036 LFSR: SEED=0, pattern 10 -> first words 01,02,04,08,11; no 8'h00 appears in 255 words.
REQ-037 Abort: en dropped after 3 accepted writes -> wrreq=0 the next cycle, state IDLE, no burst_done, fill_count=3, data holds.
REQ-038 Simultaneous: wrfull=1 and en=0 in the same FILL cycle -> burst_done=1, next state IDLE.
REQ-039 Reset mid-FILL: rst=1 for one cycle -> wrreq=0, data=SEED, fill_count=0 on that edge; no write until the next wrempty=1.
